ifetch_prefetch_unit: RTL and testbench

//  Instruction fetch unit of the KGP-RISC core; reads program memory on behalf of the PC path.

---
 rtl/ifetch_prefetch_unit.sv | 95 +++++++++
 tb/tb_ifetch_prefetch_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_prefetch_unit.sv
// ifetch_prefetch_unit: sequential instruction prefetcher with credit-limited requests and a redirect flush.
// Define IFETCH_PERF_CNT_EN to add the perf_fetched/perf_stall counters.
module ifetch_prefetch_unit #(
  parameter int DEPTH = 4,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          imem_req_valid,
  output logic [AW-1:0] imem_req_addr,
  input  logic          imem_req_ready,
  input  logic          imem_rsp_valid,
  input  logic [DW-1:0] imem_rsp_data,
  output logic          inst_valid,
  output logic [DW-1:0] inst_data,
  output logic [AW-1:0] inst_pc,
  input  logic          inst_ready
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]   perf_fetched,
  output logic [31:0]   perf_stall
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [AW-1:0] fetch_pc;
  logic [DW-1:0] fifo_data [DEPTH];
  logic [AW-1:0] fifo_pc [DEPTH];
  logic [AW-1:0] addr_q [DEPTH];
  logic [PW-1:0] rd, wr, aq_rd, aq_wr;
  logic [CW-1:0] count, outstanding, drop, outstanding_nxt;
  logic acc, rsp_ok, push, pop;
  // in-flight plus buffered words never exceed DEPTH, so a response always finds room
  assign imem_req_valid = !rst && !redirect_valid &&
                          (({1'b0, outstanding} + {1'b0, count}) < (CW+1)'(DEPTH));
  assign imem_req_addr = fetch_pc;
  assign inst_valid = count != '0;
  assign inst_data = inst_valid ? fifo_data[rd] : '0;
  assign inst_pc = inst_valid ? fifo_pc[rd] : '0;
  assign acc = imem_req_valid && imem_req_ready;
  assign rsp_ok = imem_rsp_valid && outstanding != '0;
  assign push = rsp_ok && drop == '0 && !redirect_valid;
  assign pop = inst_valid && inst_ready && !redirect_valid;
  assign outstanding_nxt = outstanding + CW'(acc) - CW'(rsp_ok);
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr] <= imem_rsp_data;
      fifo_pc[wr] <= addr_q[aq_rd];
    end
    if (acc) addr_q[aq_wr] <= fetch_pc;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= '0;
      rd <= '0;
      wr <= '0;
      aq_rd <= '0;
      aq_wr <= '0;
      count <= '0;
      outstanding <= '0;
      drop <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      aq_wr <= aq_wr + PW'(acc);
      aq_rd <= aq_rd + PW'(rsp_ok);
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~AW'(3);
        rd <= '0;
        wr <= '0;
        count <= '0;
        drop <= outstanding_nxt;
      end else begin
        if (acc) fetch_pc <= fetch_pc + AW'(4);
        wr <= wr + PW'(push);
        rd <= rd + PW'(pop);
        count <= count + CW'(push) - CW'(pop);
        if (rsp_ok && drop != '0) drop <= drop - CW'(1);
      end
    end
  end
`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(inst_valid && inst_ready);
      perf_stall <= perf_stall + 32'(inst_ready && !inst_valid);
    end
  end
`endif
endmodule

// File: tb/tb_ifetch_prefetch_unit.sv
// tb_ifetch_prefetch_unit: queue-based reference model with per-cycle compare, plus directed literal checks.
module tb_ifetch_prefetch_unit;
  logic clk = 0, rst = 1;
  logic redirect_valid = 0, imem_req_ready = 0, imem_rsp_valid = 0, inst_ready = 0;
  logic [31:0] redirect_pc = 0, imem_rsp_data = 0;
  logic imem_req_valid, inst_valid;
  logic [31:0] imem_req_addr, inst_data, inst_pc;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall;
`endif
  ifetch_prefetch_unit dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready)
`ifdef IFETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction
  // reference model: requests tagged with the redirect epoch they were issued in
  typedef struct { logic [31:0] pc; int ep; } pend_t;
  pend_t m_pend[$];
  logic [31:0] m_fifo[$];
  logic [31:0] seen[$];
  logic [31:0] m_next = 0, push_pc;
  int m_ep = 0;
  logic ev, er, do_push;
  pend_t pe;
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_valid", 32'(imem_req_valid), 0);
      chk("rst_inst_valid", 32'(inst_valid), 0);
      chk("rst_inst_data", inst_data, 0);
      chk("rst_inst_pc", inst_pc, 0);
      m_pend.delete();
      m_fifo.delete();
      m_next = 0;
      m_ep = 0;
    end else begin
      ev = m_fifo.size() != 0;
      er = (m_pend.size() + m_fifo.size() < 4) && !redirect_valid;
      chk("inst_valid", 32'(inst_valid), 32'(ev));
      if (ev) begin
        chk("inst_pc", inst_pc, m_fifo[0]);
        chk("inst_data", inst_data, memf(m_fifo[0]));
      end
      chk("req_valid", 32'(imem_req_valid), 32'(er));
      if (er) chk("req_addr", imem_req_addr, m_next);
      do_push = 0;
      if (imem_rsp_valid && m_pend.size() != 0) begin
        pe = m_pend.pop_front();
        do_push = pe.ep == m_ep && !redirect_valid;
        push_pc = pe.pc;
      end
      if (er && imem_req_ready) begin
        m_pend.push_back('{m_next, m_ep});
        m_next += 4;
      end
      if (ev && inst_ready && !redirect_valid) begin
        seen.push_back(inst_pc);
        void'(m_fifo.pop_front());
      end
      if (do_push) m_fifo.push_back(push_pc);
      if (redirect_valid) begin
        m_fifo.delete();
        m_ep++;
        m_next = redirect_pc & ~32'd3;
      end
    end
  end
  // memory responder state (stimulus side)
  typedef struct { logic [31:0] a; int due; } mq_t;
  mq_t mem_q[$];
  int cyc = 0, lat_lo = 1, lat_hi = 1, rdy_mode = 0, acc_cnt = 0;
  logic mem_drv = 0;
  task automatic step();
    logic acc, took;
    logic [31:0] a;
    @(negedge clk);
    acc = imem_req_valid && imem_req_ready;
    a = imem_req_addr;
    took = mem_drv;
    @(posedge clk);
    #1;
    cyc++;
    if (took) void'(mem_q.pop_front());
    if (acc && !rst) begin
      mem_q.push_back('{a, cyc + int'($urandom_range(lat_hi, lat_lo)) - 1});
      acc_cnt++;
    end
    if (rst) mem_q.delete();
    mem_drv = mem_q.size() > 0 && !rst;
    if (mem_drv) mem_drv = mem_q[0].due <= cyc;
    imem_rsp_valid = mem_drv;
    imem_rsp_data = mem_drv ? memf(mem_q[0].a) : 32'hDEAD_BEEF;
    imem_req_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'b0 : 1'(cyc % 2);
    redirect_valid = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    repeat (2) step();
    rst = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end
  initial begin
    repeat (3) step();
    // protocol error: response with nothing outstanding is ignored
    rdy_mode = 1;
    imem_req_ready = 0;
    rst = 0;
    imem_rsp_valid = 1;
    imem_rsp_data = 32'hBAD0_BAD0;
    step();
    step();
    chk("t0_bogus_rsp", 32'(inst_valid), 0);
    // 1: latency 1, decode always ready
    do_reset();
    rdy_mode = 0;
    imem_req_ready = 1;
    inst_ready = 1;
    repeat (2) step();
    chk("t1_first_valid", 32'(inst_valid), 1);
    chk("t1_first_pc", inst_pc, 0);
    chk("t1_first_data", inst_data, 32'h1234_5678);
    seen.delete();
    repeat (10) step();
    chk("t1_npop", 32'(seen.size()), 10);
    for (int i = 0; i < 10 && i < seen.size(); i++) chk("t1_seq", seen[i], 32'(4 * i));
    // 2: decode stalled, credit caps requests at 4
    inst_ready = 0;
    do_reset();
    acc_cnt = 0;
    repeat (20) step();
    chk("t2_accepts", 32'(acc_cnt), 4);
    chk("t2_req_off", 32'(imem_req_valid), 0);
    seen.delete();
    inst_ready = 1;
    step();
    chk("t2_resume_valid", 32'(imem_req_valid), 1);
    chk("t2_resume_addr", imem_req_addr, 32'h10);
    repeat (3) step();
    chk("t2_npop", 32'(seen.size() >= 4), 1);
    for (int i = 0; i < 4 && i < seen.size(); i++) chk("t2_order", seen[i], 32'(4 * i));
    // 3: redirect with 3 in flight
    inst_ready = 0;
    lat_lo = 3;
    lat_hi = 3;
    do_reset();
    repeat (3) step();
    chk("t3_inflight", 32'(mem_q.size()), 3);
    seen.delete();
    redirect_valid = 1;
    redirect_pc = 32'h0000_0103;
    inst_ready = 1;
    step();
    chk("t3_req_addr", imem_req_addr, 32'h100);
    repeat (15) step();
    chk("t3_first_pc", seen.size() > 0 ? seen[0] : 32'hFFFF_FFFF, 32'h100);
    // 4: address wrap
    lat_lo = 1;
    lat_hi = 1;
    seen.delete();
    redirect_valid = 1;
    redirect_pc = 32'hFFFF_FFF8;
    step();
    repeat (8) step();
    chk("t4_n", 32'(seen.size() >= 3), 1);
    if (seen.size() >= 3) begin
      chk("t4_pc0", seen[0], 32'hFFFF_FFF8);
      chk("t4_pc1", seen[1], 32'hFFFF_FFFC);
      chk("t4_pc2", seen[2], 32'h0000_0000);
    end
    // 5: toggling ready, random latency, random decode stalls
    rdy_mode = 2;
    lat_lo = 1;
    lat_hi = 3;
    seen.delete();
    redirect_valid = 1;
    redirect_pc = 32'h200;
    step();
    for (int i = 0; i < 80; i++) begin
      inst_ready = 1'($urandom_range(0, 3) != 0);
      step();
    end
    chk("t5_progress", 32'(seen.size() >= 10), 1);
    for (int i = 0; i < seen.size(); i++) chk("t5_gapfree", seen[i], 32'h200 + 32'(4 * i));
    // 6: async reset with FIFO full
    rdy_mode = 0;
    lat_lo = 1;
    lat_hi = 1;
    inst_ready = 0;
    repeat (12) step();
    chk("t6_full", 32'(m_fifo.size()), 4);
    rst = 1;
    #1;
    chk("t6_rst_req", 32'(imem_req_valid), 0);
    chk("t6_rst_iv", 32'(inst_valid), 0);
    chk("t6_rst_data", inst_data, 0);
    chk("t6_rst_pc", inst_pc, 0);
    repeat (2) step();
    inst_ready = 1;
    seen.delete();
    rst = 0;
    #1;
    chk("t6_rel_req", 32'(imem_req_valid), 1);
    chk("t6_rel_addr", imem_req_addr, 0);
    for (int g = 0; g < 40 && seen.size() < 10; g++) step();
    chk("t6_npop", 32'(seen.size()), 10);
`ifdef IFETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, 10);
    chk("perf_stall", perf_stall, 2);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
